decoder_rll: RTL and testbench
==============================

// Module: decoder_rll
// PURPOSE
//  Receive-side RLL(2,7) decoder. Consumes the NRZI line level driven by the RLL encoder stage.
//  Each sampled level yields one code bit: transition = 1, no transition = 0.
//  The code-bit stream is parsed against the RLL(2,7) codeword table.
//  Recovered data bits go out serially through a small FWFT queue with valid/ready handshake.
// PARAMETERS
//  QDEPTH     8  output queue depth in data bits; power of 2, >= 8
//  ERR_CNT_W  8  width of the saturating code-error counter
// PORTS
//  clk_i         in   1          clock; all logic on posedge
//  rst_i         in   1          synchronous reset, active-high
//  line_i        in   1          encoded NRZI line level
//  line_valid_i  in   1          line_i carries one code bit this cycle
//  data_o        out  1          decoded data bit (head of queue)
//  data_valid_o  out  1          data_o valid
//  data_ready_i  in   1          sink accepts data_o this cycle
//  code_err_o    out  1          1-cycle pulse: invalid codeword discarded
//  err_cnt_o     out  ERR_CNT_W  saturating count of code errors
//  overflow_o    out  1          sticky: decoded word dropped because queue was full
// BEHAVIOUR
//  Reset values (synchronous, active-high)
//  - prev_level=0, acc empty (len=0), state=IDLE, queue empty.
//  - Outputs: data_o=0, data_valid_o=0, code_err_o=0, err_cnt_o=0, overflow_o=0.
//  Code-bit extraction
//  - code_bit = line_i ^ prev_level.
//  - prev_level <= line_i only on edges with line_valid_i=1.
//  - line_valid_i=0 freezes all parser state.
//  FSM
//  - IDLE -> COLLECT on the first line_valid_i=1; that code bit is accumulated.
//  - COLLECT: on each valid edge, append code_bit to acc (earliest bit = MSB) and len++.
//  - A match is evaluated on the next-acc value, at len 4/6/8 only.
//  - Codewords (code -> data, time order left to right):
//      1000->11, 0100->10, 001000->011, 100100->010,
//      000100->000, 00001000->0011, 00100100->0010
//  - Match: push the data bits to the queue, first data bit first; acc cleared the same edge.
//  - len reaches 8 with no match: code_err_o=1 for one cycle, err_cnt_o+1 (saturates at all-ones),
//    acc cleared, state stays COLLECT.
//  - Reset mid-word discards acc and the queue, and returns to IDLE.
//  Latency
//  - The last code bit of a word is sampled at edge N.
//  - If the queue was empty, the first data bit has data_valid_o=1 in the cycle after edge N.
//  - Remaining bits of the word follow one per accepted handshake.
//  Queue / handshake
//  - FWFT. A pop occurs when data_valid_o && data_ready_i.
//  - data_o is stable and held while data_valid_o=1 && !data_ready_i.
//  - Push of k bits (2..4) and a pop on the same edge: net occupancy change is k-1.
//  - Push with free slots < k (counting a same-edge pop): the whole word is dropped,
//    overflow_o set sticky until reset. No partial words.
//  - data_valid_o=0 when the queue is empty; the read pointer wraps modulo QDEPTH.
// TESTING
//  1 After reset, line_i=1,1,1,1 valid -> code 1000; data 1,1 out; first bit valid the cycle after the 4th sample.
//  2 line_i=0,0,1,1,1,0,0,0 valid (code 00100100) -> data 0,0,1,0; code_err_o stays 0.
//  3 line_valid_i toggled 1/0 during word 0100 (levels 0,1,1,1) -> data 1,0 still decoded; no error.
//  4 Code 11000000 (levels 1,0,0,0,0,0,0,0) -> no data; code_err_o pulses once; err_cnt_o=1; parser
//    resumes and then decodes 1000 -> 1,1.
//  5 data_ready_i=0 while words 1000,0100,1000,1000,1000 arrive -> 8 bits queued; 5th word dropped,
//    overflow_o=1; raise ready -> 1,1,1,0,1,1,1,1 in order.
//  6 rst_i high mid-word (after 3 code bits) -> all outputs return to reset values;
//    a fresh 000100 afterwards decodes to 0,0,0.

Source files
------------

// File: rtl/decoder_rll.sv
// rtl/decoder_rll.sv - RLL(2,7) NRZI receive decoder with FWFT bit queue and error accounting
module decoder_rll #(
    parameter int QDEPTH    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 line_i,
    input  logic                 line_valid_i,
    output logic                 data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 code_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 overflow_o
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t            state;
    logic              prev_level;
    logic [6:0]        acc;
    logic [3:0]        len;
    logic [QDEPTH-1:0] mem;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic       code_bit;
    logic [7:0] next_acc;
    logic [3:0] next_len;
    logic       hit;
    logic [3:0] dbits;
    logic [2:0] dlen;
    logic       pop;
    logic       fits;
    logic       push;
    logic       drop;
    logic       word_end;
    logic [CW:0] occ_after;

    assign data_valid_o = (count != '0);
    assign data_o       = data_valid_o & mem[rd_ptr];

    // dbits holds the decoded word with the first data bit in time at bit 0
    always_comb begin
        code_bit = line_i ^ prev_level;
        next_acc = (state == IDLE) ? {7'b0, code_bit} : {acc, code_bit};
        next_len = (state == IDLE) ? 4'd1 : len + 4'd1;
        hit      = 1'b0;
        dbits    = 4'b0000;
        dlen     = 3'd0;
        case (next_len)
            4'd4: begin
                case (next_acc[3:0])
                    4'b1000: begin hit = 1'b1; dbits = 4'b0011; dlen = 3'd2; end
                    4'b0100: begin hit = 1'b1; dbits = 4'b0001; dlen = 3'd2; end
                    default: ;
                endcase
            end
            4'd6: begin
                case (next_acc[5:0])
                    6'b001000: begin hit = 1'b1; dbits = 4'b0110; dlen = 3'd3; end
                    6'b100100: begin hit = 1'b1; dbits = 4'b0010; dlen = 3'd3; end
                    6'b000100: begin hit = 1'b1; dbits = 4'b0000; dlen = 3'd3; end
                    default: ;
                endcase
            end
            4'd8: begin
                case (next_acc)
                    8'b00001000: begin hit = 1'b1; dbits = 4'b1100; dlen = 3'd4; end
                    8'b00100100: begin hit = 1'b1; dbits = 4'b0100; dlen = 3'd4; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        pop       = data_valid_o & data_ready_i;
        occ_after = {1'b0, count} + (CW+1)'(dlen) - (CW+1)'(pop);
        fits      = (occ_after <= (CW+1)'(QDEPTH));
        word_end  = hit || (next_len == 4'd8);
        push      = line_valid_i & hit & fits;
        drop      = line_valid_i & hit & ~fits;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            prev_level <= 1'b0;
            acc        <= '0;
            len        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            code_err_o <= 1'b0;
            err_cnt_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            code_err_o <= 1'b0;
            if (line_valid_i) begin
                prev_level <= line_i;
                state      <= COLLECT;
                if (word_end) begin
                    acc <= '0;
                    len <= '0;
                end else begin
                    acc <= next_acc[6:0];
                    len <= next_len;
                end
                if (!hit && next_len == 4'd8) begin
                    code_err_o <= 1'b1;
                    if (err_cnt_o != '1)
                        err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
                end
                if (drop)
                    overflow_o <= 1'b1;
            end
            // Whole words only: the fit check above already accounts for a same-edge pop
            if (push) begin
                for (int i = 0; i < 4; i++)
                    if (i < int'(dlen))
                        mem[wr_ptr + PW'(i)] <= dbits[i];
                wr_ptr <= wr_ptr + PW'(dlen);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (push ? CW'(dlen) : CW'(0)) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_decoder_rll.sv
// tb/tb_decoder_rll.sv - scoreboard bench for decoder_rll against a codeword-table reference model
module tb_decoder_rll;
    localparam int QDEPTH = 8;
    localparam int ERR_MAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b0;
    logic       line_valid = 1'b0;
    logic       data;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       code_err;
    logic [7:0] err_cnt;
    logic       overflow;

    always #5 clk = ~clk;

    decoder_rll #(.QDEPTH(QDEPTH), .ERR_CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .line_i      (line),
        .line_valid_i(line_valid),
        .data_o      (data),
        .data_valid_o(data_valid),
        .data_ready_i(data_ready),
        .code_err_o  (code_err),
        .err_cnt_o   (err_cnt),
        .overflow_o  (overflow)
    );

    // Codeword table, written in time order (first bit = MSB)
    int code_tab[7] = '{'b1000, 'b0100, 'b001000, 'b100100, 'b000100, 'b00001000, 'b00100100};
    int clen_tab[7] = '{4, 4, 6, 6, 6, 8, 8};
    int data_tab[7] = '{'b11, 'b10, 'b011, 'b010, 'b000, 'b0011, 'b0010};
    int dlen_tab[7] = '{2, 2, 3, 3, 3, 4, 4};

    int vectors = 0;
    int miscompares = 0;
    bit exp_q[$];
    bit exp_err = 0;
    int exp_cnt = 0;
    bit exp_ovf = 0;
    bit active = 0;
    bit level = 0;
    int acc_v = 0;
    int acc_n = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (active) begin
            check("data_valid", int'(data_valid), int'(exp_q.size() != 0));
            if (data_valid && exp_q.size() != 0) begin
                check("data", int'(data), int'(exp_q[0]));
                if (data_ready)
                    void'(exp_q.pop_front());
            end
            check("code_err", int'(code_err), int'(exp_err));
            check("err_cnt", int'(err_cnt), exp_cnt);
            check("overflow", int'(overflow), int'(exp_ovf));
        end
    end

    task automatic model_bit(input bit b);
        int found;
        acc_v = (acc_v << 1) | int'(b);
        acc_n++;
        if (acc_n == 4 || acc_n == 6 || acc_n == 8) begin
            found = -1;
            for (int t = 0; t < 7; t++)
                if (clen_tab[t] == acc_n && code_tab[t] == acc_v)
                    found = t;
            if (found >= 0) begin
                if (exp_q.size() + dlen_tab[found] <= QDEPTH) begin
                    for (int i = 0; i < dlen_tab[found]; i++)
                        exp_q.push_back(bit'((data_tab[found] >> (dlen_tab[found] - 1 - i)) & 1));
                end else begin
                    exp_ovf = 1;
                end
                acc_v = 0;
                acc_n = 0;
            end else if (acc_n == 8) begin
                exp_err = 1;
                if (exp_cnt < ERR_MAX)
                    exp_cnt++;
                acc_v = 0;
                acc_n = 0;
            end
        end
    endtask

    // One clock: drive at +1, then advance the model after the monitor's sample
    task automatic cycle(input bit r, input bit lv, input bit b);
        @(posedge clk);
        #1;
        rst = r;
        line_valid = lv;
        if (lv) begin
            level = level ^ b;
            line = level;
        end else begin
            line = 1'($urandom_range(0, 1));
        end
        case (rdy_mode)
            0: data_ready = 1'b0;
            1: data_ready = 1'b1;
            default: data_ready = ($urandom_range(0, 9) < 7);
        endcase
        #5;
        exp_err = 0;
        if (r) begin
            exp_q.delete();
            exp_cnt = 0;
            exp_ovf = 0;
            level = 0;
            acc_v = 0;
            acc_n = 0;
        end else if (lv) begin
            model_bit(b);
        end
    endtask

    task automatic send_code(input int code, input int n, input int gap_mode);
        for (int i = n - 1; i >= 0; i--) begin
            if (gap_mode == 2 || (gap_mode == 1 && $urandom_range(0, 2) == 0))
                cycle(0, 0, 0);
            cycle(0, 1, bit'((code >> i) & 1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        active = 1;
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(data_valid), 0);
        check("rst_err", int'(code_err), 0);
        check("rst_cnt", int'(err_cnt), 0);
        check("rst_ovf", int'(overflow), 0);
    endtask

    initial begin
        int pick;
        rdy_mode = 1;
        do_reset();

        send_code('b1000, 4, 0);
        idle(4);
        send_code('b00100100, 8, 0);
        idle(6);
        send_code('b0100, 4, 2);
        idle(4);
        send_code('b11000000, 8, 0);
        send_code('b1000, 4, 0);
        idle(4);

        rdy_mode = 0;
        send_code('b1000, 4, 0);
        send_code('b0100, 4, 0);
        send_code('b1000, 4, 0);
        send_code('b1000, 4, 0);
        send_code('b1000, 4, 0);
        idle(3);
        rdy_mode = 1;
        idle(12);

        send_code('b001, 3, 0);
        do_reset();
        send_code('b000100, 6, 0);
        idle(6);

        for (int w = 0; w < 260; w++)
            send_code('hFF, 8, 0);
        idle(2);
        do_reset();

        rdy_mode = 2;
        for (int w = 0; w < 400; w++) begin
            if ($urandom_range(0, 7) == 0) begin
                pick = $urandom_range(1, 8);
                send_code(int'($urandom_range(0, 255)) & ((1 << pick) - 1), pick, 1);
            end else begin
                pick = $urandom_range(0, 6);
                send_code(code_tab[pick], clen_tab[pick], 1);
            end
        end
        rdy_mode = 1;
        idle(40);
        check("drain_empty", exp_q.size(), 0);
        active = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
